// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared encodings for the data-memory bus responder
package mem_bus_pkg;
  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_WORD = 2'b10;
  localparam logic [31:0] OFF_DISP = 32'h0;
  localparam logic [31:0] OFF_TIMER = 32'h4;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/load_align_ext.sv
// load_align_ext: picks the addressed little-endian lanes of a word and sign/zero extends them
module load_align_ext
  import mem_bus_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  width,
  input  logic        sign,
  input  logic [31:0] word,
  output logic [31:0] rdata
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = word[8*addr_lo +: 8];
    h = addr_lo[1] ? word[31:16] : word[15:0];
    rdata = width == W_BYTE ? {{24{sign & b[7]}}, b} :
            width == W_HALF ? {{16{sign & h[15]}}, h} : word;
  end
endmodule

// File: rtl/mem_bus_responder.sv
// mem_bus_responder: wait-stated load/store responder with byte-enable RAM and MMIO display
// register; define MMIO_TIMER_EN to add a read-only cycle counter at MMIO_BASE+4.
module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] DATA_BASE   = 32'h10010000,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_we,
  input  logic [1:0]  req_width,
  input  logic        req_sign,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] disp_data
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = WAIT_STATES > 1 ? $clog2(WAIT_STATES) : 1;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [31:0] lat_addr, lat_wdata;
  logic [1:0]  lat_width;
  logic        lat_we, lat_sign;
  logic [31:0] a, wd, off, ram_word, src, ld_data, st_data;
  logic [1:0]  w;
  logic        we, sgn, accept, commit, in_ram, is_disp, tmr_ok, bad_align, err;
  logic [3:0]  be;
  logic [AW-1:0] idx;
  logic [31:0] ram [DEPTH_WORDS];
  assign req_ready  = state == IDLE;
  assign resp_valid = state == RESP;
  assign accept     = req_valid && req_ready;
  // In IDLE the live request is decoded so a zero-wait accept can commit on its own edge
  assign a   = req_ready ? req_addr : lat_addr;
  assign wd  = req_ready ? req_wdata : lat_wdata;
  assign w   = req_ready ? req_width : lat_width;
  assign we  = req_ready ? req_we : lat_we;
  assign sgn = req_ready ? req_sign : lat_sign;
  assign off      = a - DATA_BASE;
  assign in_ram   = off < 32'(4 * DEPTH_WORDS);
  assign idx      = off[AW+1:2];
  assign ram_word = ram[idx];
  assign is_disp  = a == MMIO_BASE + OFF_DISP;
`ifdef MMIO_TIMER_EN
  logic [31:0] timer, lat_timer;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer     <= '0;
      lat_timer <= '0;
    end else begin
      timer <= timer + 32'd1;
      if (accept) lat_timer <= timer;
    end
  end
  assign tmr_ok = a == MMIO_BASE + OFF_TIMER && !we && w == W_WORD;
  assign src    = in_ram ? ram_word : is_disp ? disp_data : (req_ready ? timer : lat_timer);
`else
  assign tmr_ok = 1'b0;
  assign src    = in_ram ? ram_word : disp_data;
`endif
  assign bad_align = w == W_HALF ? a[0] : w == W_WORD ? |a[1:0] : w != W_BYTE;
  assign err       = bad_align || !(in_ram || (is_disp && w == W_WORD) || tmr_ok);
  assign be      = w == W_BYTE ? 4'b0001 << a[1:0] : w == W_HALF ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign st_data = w == W_BYTE ? {4{wd[7:0]}} : w == W_HALF ? {2{wd[15:0]}} : wd;
  load_align_ext u_ext (
    .addr_lo (a[1:0]),
    .width   (w),
    .sign    (sgn),
    .word    (src),
    .rdata   (ld_data)
  );
  always_comb begin
    state_n = state == IDLE ? (req_valid ? (WAIT_STATES == 0 ? RESP : WAIT) : IDLE) :
              state == WAIT ? (int'(cnt) == WAIT_STATES - 1 ? RESP : WAIT) : IDLE;
  end
  assign commit = state_n == RESP;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_width  <= '0;
      lat_we     <= 1'b0;
      lat_sign   <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      disp_data  <= '0;
    end else begin
      state <= state_n;
      cnt   <= state == WAIT ? cnt + 1'b1 : '0;
      if (accept) begin
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_width <= req_width;
        lat_we    <= req_we;
        lat_sign  <= req_sign;
      end
      resp_rdata <= commit && !err && !we ? ld_data : '0;
      resp_err   <= commit && err;
      if (commit && !err && we && is_disp) disp_data <= wd;
    end
  end
  always_ff @(posedge clk) begin
    if (commit && !err && we && in_ram && !reset)
      for (int i = 0; i < 4; i++)
        if (be[i]) ram[idx][8*i +: 8] <= st_data[8*i +: 8];
  end
endmodule

// File: tb/tb_mem_bus_responder.sv
// tb_mem_bus_responder: directed load/store/MMIO/reset checks with hand-computed expectations
module tb_mem_bus_responder;
  localparam logic [31:0] DB = 32'h10010000;
  localparam logic [31:0] MB = 32'hFFFF0000;
  logic clk = 1'b0, reset = 1'b0;
  logic req_valid = 1'b0, req_we = 1'b0, req_sign = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0] req_width = '0;
  logic req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata, disp_data;
  int n_assert = 0, n_fail = 0, lat = 0;
  logic [31:0] rd, dp, t0;
  logic er, seen;
  always #5 clk = ~clk;
  mem_bus_responder dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_we     (req_we),
    .req_width  (req_width),
    .req_sign   (req_sign),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .disp_data  (disp_data)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic start(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                       input logic [1:0] width, input logic sign);
    int k;
    k = 0;
    @(negedge clk);
    req_addr = addr; req_wdata = wdata; req_we = we; req_width = width; req_sign = sign;
    req_valid = 1'b1;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask
  task automatic finish_x();
    lat = 0;
    for (int n = 1; n <= 10 && lat == 0; n++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = n; rd = resp_rdata; er = resp_err; dp = disp_data;
      end
    end
  endtask
  task automatic run(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic we, input logic [1:0] width, input logic sign,
                     input logic [31:0] exp_rd, input logic exp_er);
    start(addr, wdata, we, width, sign);
    finish_x();
    chk({tag, "_lat"}, 32'(lat), 32'd3);
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_err"}, 32'(er), 32'(exp_er));
  endtask
  initial begin
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    chk("rst_disp", disp_data, 32'd0);
    reset = 1'b0;
    run("sw", DB, 32'hDEADBEEF, 1'b1, 2'b10, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    chk("sw_pulse", 32'(resp_valid), 32'd0);
    run("lw", DB, 32'h0, 1'b0, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0);
    run("lb", DB + 3, 32'h0, 1'b0, 2'b00, 1'b1, 32'hFFFFFFDE, 1'b0);
    run("lbu", DB + 3, 32'h0, 1'b0, 2'b00, 1'b0, 32'h000000DE, 1'b0);
    run("lh", DB + 2, 32'h0, 1'b0, 2'b01, 1'b1, 32'hFFFFDEAD, 1'b0);
    run("lhu", DB, 32'h0, 1'b0, 2'b01, 1'b0, 32'h0000BEEF, 1'b0);
    run("sb", DB + 1, 32'hABCDEF12, 1'b1, 2'b00, 1'b0, 32'h0, 1'b0);
    run("lw_sb", DB, 32'h0, 1'b0, 2'b10, 1'b0, 32'hDEAD12EF, 1'b0);
    run("lw_mis", DB + 2, 32'h0, 1'b0, 2'b10, 1'b0, 32'h0, 1'b1);
    run("sh_mis", DB + 1, 32'h0000FFFF, 1'b1, 2'b01, 1'b0, 32'h0, 1'b1);
    run("w11", DB, 32'h0, 1'b0, 2'b11, 1'b0, 32'h0, 1'b1);
    run("lw_keep", DB, 32'h0, 1'b0, 2'b10, 1'b0, 32'hDEAD12EF, 1'b0);
    run("sw_disp", MB, 32'h00C0FFEE, 1'b1, 2'b10, 1'b0, 32'h0, 1'b0);
    chk("disp_at_resp", dp, 32'h00C0FFEE);
    run("lw_disp", MB, 32'h0, 1'b0, 2'b10, 1'b0, 32'h00C0FFEE, 1'b0);
    run("sb_disp", MB, 32'h77, 1'b1, 2'b00, 1'b0, 32'h0, 1'b1);
    chk("disp_keep", disp_data, 32'h00C0FFEE);
    run("sh_last", DB + 4094, 32'h1234A5A5, 1'b1, 2'b01, 1'b0, 32'h0, 1'b0);
    run("lh_last", DB + 4094, 32'h0, 1'b0, 2'b01, 1'b1, 32'hFFFFA5A5, 1'b0);
    run("over", DB + 4096, 32'h0, 1'b0, 2'b10, 1'b0, 32'h0, 1'b1);
    run("under", DB - 4, 32'h0, 1'b0, 2'b10, 1'b0, 32'h0, 1'b1);
    run("pre8", DB + 8, 32'h11111111, 1'b1, 2'b10, 1'b0, 32'h0, 1'b0);
    start(DB + 8, 32'h55, 1'b1, 2'b10, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_disp", disp_data, 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    reset = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    chk("no_resp", 32'(seen), 32'd0);
    run("lw8", DB + 8, 32'h0, 1'b0, 2'b10, 1'b0, 32'h11111111, 1'b0);
`ifdef MMIO_TIMER_EN
    start(MB + 4, 32'h0, 1'b0, 2'b10, 1'b0);
    finish_x();
    chk("tmr0_lat", 32'(lat), 32'd3);
    t0 = rd;
    start(MB + 4, 32'h0, 1'b0, 2'b10, 1'b0);
    finish_x();
    chk("tmr1_lat", 32'(lat), 32'd3);
    chk("tmr_diff", rd - t0, 32'd4);
    run("tmr_sw", MB + 4, 32'h1, 1'b1, 2'b10, 1'b0, 32'h0, 1'b1);
`else
    run("tmr_off", MB + 4, 32'h0, 1'b0, 2'b10, 1'b0, 32'h0, 1'b1);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
